// File: rtl/instr_encoder_loader_pkg.sv
// Field layout, group/state encodings and the record-to-word encoder shared by the
// Frost32 instruction encoder/loader and decoder.
package PkgInstrEncoder;

    localparam int INSTR_W    = 32;
    localparam int FIELD_W    = 4;
    localparam int IMM16_W    = 16;
    localparam int IMM12_W    = 12;
    localparam int GRP_LSB    = 28;
    localparam int RA_LSB     = 24;
    localparam int RB_LSB     = 20;
    localparam int RC_LSB     = 16;
    localparam int OP_LSB     = 12;
    localparam int OP_IMM_LSB = 16;
    localparam int IMM_LSB    = 0;

    typedef enum logic [3:0] {
        GRP_R0  = 4'd0,
        GRP_I1  = 4'd1,
        GRP_I2  = 4'd2,
        GRP_R3  = 4'd3,
        GRP_R4  = 4'd4,
        GRP_S5  = 4'd5,
        GRP_R6  = 4'd6
    } group_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_e;

    typedef struct packed {
        logic [INSTR_W-1:0] word;
        logic               err_bad_group;
        logic               err_imm_range;
    } enc_result_t;

    function automatic enc_result_t encode(
        input logic [3:0]  grp,
        input logic [3:0]  ra,
        input logic [3:0]  rb,
        input logic [3:0]  rc,
        input logic [3:0]  opcode,
        input logic [15:0] imm
    );
        enc_result_t r;
        r = '0;
        case (grp)
            GRP_R0, GRP_R3, GRP_R4, GRP_R6: begin
                r.word[GRP_LSB +: FIELD_W] = grp;
                r.word[RA_LSB  +: FIELD_W] = ra;
                r.word[RB_LSB  +: FIELD_W] = rb;
                r.word[RC_LSB  +: FIELD_W] = rc;
                r.word[OP_LSB  +: FIELD_W] = opcode;
            end
            GRP_I1, GRP_I2: begin
                r.word[GRP_LSB    +: FIELD_W] = grp;
                r.word[RA_LSB     +: FIELD_W] = ra;
                r.word[RB_LSB     +: FIELD_W] = rb;
                r.word[OP_IMM_LSB +: FIELD_W] = opcode;
                r.word[IMM_LSB    +: IMM16_W] = imm;
            end
            GRP_S5: begin
                r.word[GRP_LSB +: FIELD_W] = grp;
                r.word[RA_LSB  +: FIELD_W] = ra;
                r.word[RB_LSB  +: FIELD_W] = rb;
                r.word[RC_LSB  +: FIELD_W] = rc;
                r.word[OP_LSB  +: FIELD_W] = opcode;
                r.word[IMM_LSB +: IMM12_W] = imm[IMM12_W-1:0];
                // Word is still emitted (truncated) when imm does not fit in 12 signed bits.
                r.err_imm_range = !((&imm[15:11]) || !(|imm[15:11]));
            end
            default: r.err_bad_group = 1'b1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/instr_encoder_loader_fifo.sv
// Small synchronous FIFO with registered storage; push when full and pop when empty
// are ignored.
module sync_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (PTR_W + 1)'(1);
            2'b01:   count_d = count_q - (PTR_W + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// Streaming program loader: encodes field records into Frost32 words, buffers them and
// writes them to instruction memory at consecutive addresses.
module instr_encoder_loader
    import PkgInstrEncoder::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int ADDR_WIDTH  = 32,
    parameter int ADDR_STRIDE = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            in_group,
    input  logic [3:0]            in_ra,
    input  logic [3:0]            in_rb,
    input  logic [3:0]            in_rc,
    input  logic [3:0]            in_opcode,
    input  logic [15:0]           in_imm_val,
    input  logic                  in_last,
    output logic                  mem_req,
    input  logic                  mem_ack,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_data,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           words_written,
    output logic                  err_bad_group,
    output logic                  err_imm_range
);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [15:0]           ww_q, ww_d;
    logic                  err_bad_q, err_bad_d;
    logic                  err_imm_q, err_imm_d;

    logic                  fifo_full, fifo_empty;
    logic [INSTR_W:0]      fifo_dout;
    logic                  push, pop, active;
    enc_result_t           enc;

    assign enc      = encode(in_group, in_ra, in_rb, in_rc, in_opcode, in_imm_val);
    assign active   = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign in_ready = (state_q == ST_RUN) && !fifo_full;
    assign push     = in_valid && in_ready;
    assign mem_req  = active && !fifo_empty;
    assign pop      = mem_req && mem_ack;

    sync_fifo #(
        .WIDTH (INSTR_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   ({in_last, enc.word}),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        ww_d      = ww_q;
        err_bad_d = err_bad_q;
        err_imm_d = err_imm_q;
        case (state_q)
            ST_IDLE: if (start) begin
                state_d   = ST_RUN;
                addr_d    = base_addr;
                ww_d      = '0;
                err_bad_d = 1'b0;
                err_imm_d = 1'b0;
            end
            ST_RUN:   if (push && in_last) state_d = ST_DRAIN;
            // The last-tagged entry is the final one in the FIFO; its ack ends the program.
            ST_DRAIN: if (fifo_empty || (pop && fifo_dout[INSTR_W])) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (push) begin
            err_bad_d = err_bad_d | enc.err_bad_group;
            err_imm_d = err_imm_d | enc.err_imm_range;
        end
        if (pop) begin
            addr_d = addr_q + ADDR_WIDTH'(ADDR_STRIDE);
            ww_d   = ww_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            ww_q      <= '0;
            err_bad_q <= 1'b0;
            err_imm_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            ww_q      <= ww_d;
            err_bad_q <= err_bad_d;
            err_imm_q <= err_imm_d;
        end
    end

    assign mem_addr      = addr_q;
    assign mem_data      = fifo_dout[INSTR_W-1:0];
    assign busy          = (state_q != ST_IDLE);
    assign done          = (state_q == ST_DONE);
    assign words_written = ww_q;
    assign err_bad_group = err_bad_q;
    assign err_imm_range = err_imm_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader: encoding, backpressure, address wrap and reset.
module tb_instr_encoder_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] base_addr = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_group = '0, in_ra = '0, in_rb = '0, in_rc = '0, in_opcode = '0;
    logic [15:0] in_imm_val = '0;
    logic        in_last = 1'b0;
    logic        mem_req;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_addr, mem_data;
    logic        busy, done;
    logic [15:0] words_written;
    logic        err_bad_group, err_imm_range;

    int vec = 0;
    int miss = 0;

    logic [31:0] wa[$];
    logic [31:0] wd[$];
    int done_cnt = 0;
    int acc_cnt = 0;
    int req_cnt = 0;

    instr_encoder_loader dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .base_addr     (base_addr),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_group      (in_group),
        .in_ra         (in_ra),
        .in_rb         (in_rb),
        .in_rc         (in_rc),
        .in_opcode     (in_opcode),
        .in_imm_val    (in_imm_val),
        .in_last       (in_last),
        .mem_req       (mem_req),
        .mem_ack       (mem_ack),
        .mem_addr      (mem_addr),
        .mem_data      (mem_data),
        .busy          (busy),
        .done          (done),
        .words_written (words_written),
        .err_bad_group (err_bad_group),
        .err_imm_range (err_imm_range)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n) begin
            if (mem_req && mem_ack) begin
                wa.push_back(mem_addr);
                wd.push_back(mem_data);
            end
            if (done) done_cnt++;
            if (in_valid && in_ready) acc_cnt++;
            if (mem_req) req_cnt++;
        end
    end

    // Stimulus helpers; every task starts and ends 1 time unit after a rising edge.
    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0;
        in_valid = 1'b0;
        mem_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [31:0] b);
        start = 1'b1;
        base_addr = b;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic send(input logic [3:0] g, input logic [3:0] ra, input logic [3:0] rb,
                        input logic [3:0] rc, input logic [3:0] op, input logic [15:0] imm,
                        input logic last);
        logic ok;
        ok = 1'b0;
        in_valid = 1'b1;
        in_group = g; in_ra = ra; in_rb = rb; in_rc = rc; in_opcode = op;
        in_imm_val = imm; in_last = last;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last = 1'b0;
        if (!ok) begin
            vec++; miss++;
            $display("FAIL send_timeout: record g=%0h never accepted, required acceptance", g);
        end
    endtask

    task automatic wait_idle(input string name);
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (!busy) break;
        end
        vec++;
        if (busy !== 1'b0) begin
            miss++;
            $display("FAIL %s_idle_timeout: busy=%b, required 0", name, busy);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        vec++;
        if ({in_ready, mem_req, busy, done, err_bad_group, err_imm_range} !== 6'b0) begin
            miss++;
            $display("FAIL reset_flags: got %b, required 000000",
                     {in_ready, mem_req, busy, done, err_bad_group, err_imm_range});
        end
        vec++;
        if (mem_addr !== 32'h0 || mem_data !== 32'h0 || words_written !== 16'h0) begin
            miss++;
            $display("FAIL reset_values: addr=%h data=%h ww=%0d, required 0/0/0",
                     mem_addr, mem_data, words_written);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        int n0, d0;
        do_reset();
        n0 = wa.size(); d0 = done_cnt;
        mem_ack = 1'b1;
        pulse_start(32'h1000);
        send(4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 16'h0, 1'b1);
        wait_idle("basic");
        vec++;
        if (wa.size() - n0 !== 1) begin
            miss++;
            $display("FAIL basic_count: got %0d writes, required 1", wa.size() - n0);
        end else begin
            vec++;
            if (wd[n0] !== 32'h01234000 || wa[n0] !== 32'h1000) begin
                miss++;
                $display("FAIL basic_write: got %h@%h, required 01234000@00001000", wd[n0], wa[n0]);
            end
        end
        vec++;
        if (done_cnt - d0 !== 1) begin
            miss++;
            $display("FAIL basic_done: got %0d pulses, required 1", done_cnt - d0);
        end
        vec++;
        if (words_written !== 16'd1) begin
            miss++;
            $display("FAIL basic_ww: got %0d, required 1", words_written);
        end
    endtask

    task automatic test_imm_groups();
        int n0;
        do_reset();
        n0 = wa.size();
        mem_ack = 1'b1;
        pulse_start(32'h2000);
        send(4'h1, 4'h5, 4'h6, 4'h0, 4'h2, 16'hBEEF, 1'b0);
        send(4'h5, 4'h1, 4'h2, 4'h3, 4'h1, 16'hFFF8, 1'b1);
        wait_idle("imm");
        vec++;
        if (wa.size() - n0 !== 2) begin
            miss++;
            $display("FAIL imm_count: got %0d writes, required 2", wa.size() - n0);
        end else begin
            vec++;
            if (wd[n0] !== 32'h1562BEEF || wa[n0] !== 32'h2000) begin
                miss++;
                $display("FAIL imm_g1: got %h@%h, required 1562beef@00002000", wd[n0], wa[n0]);
            end
            vec++;
            if (wd[n0+1] !== 32'h51231FF8 || wa[n0+1] !== 32'h2004) begin
                miss++;
                $display("FAIL imm_g5: got %h@%h, required 51231ff8@00002004", wd[n0+1], wa[n0+1]);
            end
        end
        vec++;
        if ({err_bad_group, err_imm_range} !== 2'b00) begin
            miss++;
            $display("FAIL imm_errs: got %b, required 00", {err_bad_group, err_imm_range});
        end
    endtask

    task automatic test_errors();
        int n0;
        do_reset();
        n0 = wa.size();
        mem_ack = 1'b1;
        pulse_start(32'h0);
        send(4'h5, 4'h1, 4'h2, 4'h3, 4'h1, 16'h0800, 1'b0);
        @(negedge clk);
        vec++;
        if ({err_bad_group, err_imm_range} !== 2'b01) begin
            miss++;
            $display("FAIL err_imm_set: got bad/imm=%b, required 01", {err_bad_group, err_imm_range});
        end
        @(posedge clk);
        #1;
        send(4'h9, 4'hF, 4'hF, 4'hF, 4'hF, 16'hFFFF, 1'b1);
        wait_idle("err");
        vec++;
        if (wa.size() - n0 !== 2) begin
            miss++;
            $display("FAIL err_count: got %0d writes, required 2", wa.size() - n0);
        end else begin
            vec++;
            if (wd[n0] !== 32'h51231800 || wd[n0+1] !== 32'h00000000) begin
                miss++;
                $display("FAIL err_words: got %h,%h, required 51231800,00000000", wd[n0], wd[n0+1]);
            end
        end
        vec++;
        if ({err_bad_group, err_imm_range} !== 2'b11) begin
            miss++;
            $display("FAIL err_sticky: got bad/imm=%b, required 11", {err_bad_group, err_imm_range});
        end
        pulse_start(32'h100);
        @(negedge clk);
        vec++;
        if ({err_bad_group, err_imm_range, busy} !== 3'b001) begin
            miss++;
            $display("FAIL err_clear: got bad/imm/busy=%b, required 001",
                     {err_bad_group, err_imm_range, busy});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        int n0, a0;
        logic stable;
        logic [31:0] exp_bp [6];
        exp_bp[0] = 32'h00234000; exp_bp[1] = 32'h01234000; exp_bp[2] = 32'h02234000;
        exp_bp[3] = 32'h03234000; exp_bp[4] = 32'h04234000; exp_bp[5] = 32'h05234000;
        do_reset();
        n0 = wa.size(); a0 = acc_cnt;
        stable = 1'b1;
        mem_ack = 1'b0;
        pulse_start(32'h3000);
        fork
            begin
                for (int i = 0; i < 6; i++) send(4'h0, 4'(i), 4'h2, 4'h3, 4'h4, 16'h0, i == 5);
            end
            begin
                for (int c = 0; c < 10; c++) begin
                    @(negedge clk);
                    if (mem_req && (mem_addr !== 32'h3000 || mem_data !== 32'h00234000)) stable = 1'b0;
                end
                vec++;
                if (acc_cnt - a0 !== 4) begin
                    miss++;
                    $display("FAIL bp_accepted: got %0d, required 4", acc_cnt - a0);
                end
                vec++;
                if (in_ready !== 1'b0 || mem_req !== 1'b1) begin
                    miss++;
                    $display("FAIL bp_handshake: in_ready=%b mem_req=%b, required 0/1", in_ready, mem_req);
                end
                vec++;
                if (!stable) begin
                    miss++;
                    $display("FAIL bp_stable: addr=%h data=%h, required 00003000/00234000", mem_addr, mem_data);
                end
                @(posedge clk);
                #1 mem_ack = 1'b1;
            end
        join
        wait_idle("bp");
        vec++;
        if (wa.size() - n0 !== 6) begin
            miss++;
            $display("FAIL bp_count: got %0d writes, required 6", wa.size() - n0);
        end else begin
            for (int i = 0; i < 6; i++) begin
                vec++;
                if (wd[n0+i] !== exp_bp[i] || wa[n0+i] !== 32'h3000 + 32'(4 * i)) begin
                    miss++;
                    $display("FAIL bp_write%0d: got %h@%h, required %h@%h", i, wd[n0+i], wa[n0+i],
                             exp_bp[i], 32'h3000 + 32'(4 * i));
                end
            end
        end
        vec++;
        if (words_written !== 16'd6) begin
            miss++;
            $display("FAIL bp_ww: got %0d, required 6", words_written);
        end
    endtask

    task automatic test_addr_wrap();
        int n0;
        do_reset();
        n0 = wa.size();
        mem_ack = 1'b1;
        pulse_start(32'hFFFFFFFC);
        send(4'h3, 4'h7, 4'h8, 4'h9, 4'hA, 16'h0, 1'b0);
        send(4'h6, 4'h1, 4'h1, 4'h1, 4'h1, 16'h0, 1'b1);
        wait_idle("wrap");
        vec++;
        if (wa.size() - n0 !== 2) begin
            miss++;
            $display("FAIL wrap_count: got %0d writes, required 2", wa.size() - n0);
        end else begin
            vec++;
            if (wa[n0] !== 32'hFFFFFFFC || wa[n0+1] !== 32'h00000000) begin
                miss++;
                $display("FAIL wrap_addr: got %h,%h, required fffffffc,00000000", wa[n0], wa[n0+1]);
            end
            vec++;
            if (wd[n0] !== 32'h3789A000 || wd[n0+1] !== 32'h61111000) begin
                miss++;
                $display("FAIL wrap_data: got %h,%h, required 3789a000,61111000", wd[n0], wd[n0+1]);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        int n0, r0;
        do_reset();
        mem_ack = 1'b0;
        pulse_start(32'h4000);
        for (int i = 0; i < 3; i++) send(4'h0, 4'(i), 4'h0, 4'h0, 4'h0, 16'h0, 1'b0);
        @(negedge clk);
        vec++;
        if (mem_req !== 1'b1 || busy !== 1'b1) begin
            miss++;
            $display("FAIL mid_pre: mem_req=%b busy=%b, required 1/1", mem_req, busy);
        end
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        vec++;
        if ({in_ready, mem_req, busy, done, err_bad_group, err_imm_range} !== 6'b0 ||
            mem_addr !== 32'h0 || mem_data !== 32'h0 || words_written !== 16'h0) begin
            miss++;
            $display("FAIL mid_reset: flags=%b addr=%h data=%h ww=%0d, required all 0",
                     {in_ready, mem_req, busy, done, err_bad_group, err_imm_range},
                     mem_addr, mem_data, words_written);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        mem_ack = 1'b1;
        n0 = wa.size(); r0 = req_cnt;
        repeat (5) @(posedge clk);
        #1;
        vec++;
        if (req_cnt !== r0 || wa.size() !== n0) begin
            miss++;
            $display("FAIL mid_no_req: got %0d req cycles, %0d writes, required 0/0",
                     req_cnt - r0, wa.size() - n0);
        end
        // start inside RUN must not reload the base address
        pulse_start(32'h5000);
        send(4'h4, 4'h1, 4'h2, 4'h3, 4'h4, 16'h0, 1'b0);
        pulse_start(32'h6000);
        send(4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 16'h0, 1'b1);
        wait_idle("mid");
        vec++;
        if (wa.size() - n0 !== 2) begin
            miss++;
            $display("FAIL mid_count: got %0d writes, required 2", wa.size() - n0);
        end else begin
            vec++;
            if (wa[n0] !== 32'h5000 || wa[n0+1] !== 32'h5004 ||
                wd[n0] !== 32'h41234000 || wd[n0+1] !== 32'h45678000) begin
                miss++;
                $display("FAIL mid_start_ignored: got %h@%h,%h@%h, required 41234000@5000,45678000@5004",
                         wd[n0], wa[n0], wd[n0+1], wa[n0+1]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_imm_groups();
        test_errors();
        test_back_to_back();
        test_addr_wrap();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Streaming instruction encoder and program loader for the Frost32 core; the write-side counterpart of the instruction decoder.
- Accepts decoded-field records over a valid/ready handshake and packs each into a 32-bit instruction word.
- Buffers words in a small FIFO and writes them to instruction memory at consecutive addresses over a req/ack bus.
- Used by the debug/boot path to load programs into instruction memory.

Parameters:
FIFO_DEPTH, 4, encoded-word buffer entries; power of two, >= 2
ADDR_WIDTH, 32, memory address width
ADDR_STRIDE, 4, address increment per word written

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
start  in  1  one-cycle pulse; loads base_addr, clears counters/errors; honoured only in IDLE
base_addr  in  ADDR_WIDTH  first write address
in_valid  in  1  field record valid
in_ready  out  1  record accepted when in_valid && in_ready
in_group  in  4  instruction group
in_ra, in_rb, in_rc  in  4 each  register indices
in_opcode  in  4  opcode
in_imm_val  in  16  immediate (groups 1, 2, 5)
in_last  in  1  marks final record of program
mem_req  out  1  write request
mem_ack  in  1  write accepted this cycle
mem_addr  out  ADDR_WIDTH  write address
mem_data  out  32  encoded word
busy  out  1  state != IDLE
done  out  1  one-cycle pulse when last word acked
words_written  out  16  acked word count, wraps at 2^16
err_bad_group  out  1  sticky: group > 6 seen
err_imm_range  out  1  sticky: group-5 imm not 12-bit sign-extendable

Behaviour:
- Reset values: in_ready=0, mem_req=0, mem_addr=0, mem_data=0, busy=0, done=0, words_written=0, both err flags=0, FIFO empty, state IDLE.
- Reset asserted mid-operation discards FIFO contents and any outstanding request; no write completes.
- Encoding is combinational at acceptance.
  - Groups 0,3,4,6: [31:28] group, [27:24] ra, [23:20] rb, [19:16] rc, [15:12] opcode, [11:0] zero.
  - Groups 1,2: group, ra, rb, [19:16] opcode, [15:0] imm.
  - Group 5: group, ra, rb, rc, [15:12] opcode, [11:0] imm[11:0]. imm[15:11] must be all equal, else set err_imm_range; the word is still emitted, truncated.
  - Group > 6: emit 0x00000000 (NOP); set err_bad_group.
- States: IDLE, RUN, DRAIN, DONE.
  - IDLE: start -> RUN; mem_addr=base_addr, words_written=0, errors cleared.
  - RUN: in_ready = !fifo_full. Accepting a record with in_last=1 -> DRAIN.
  - DRAIN: in_ready=0. FIFO empty and no request pending -> DONE.
  - DONE: done=1 for one cycle -> IDLE.
  - start outside IDLE is ignored.
- Memory side:
  - mem_req=1 whenever the FIFO is non-empty in RUN or DRAIN.
  - mem_addr and mem_data hold stable while mem_req && !mem_ack.
  - On ack: pop one entry, mem_addr += ADDR_STRIDE (wraps modulo 2^ADDR_WIDTH), words_written += 1.
  - mem_ack while mem_req=0 is ignored.
- Latency: a record accepted at cycle N drives mem_req at cycle N+1 at the earliest; FIFO output is registered, with no combinational in->mem path.
- FIFO boundaries:
  - Push and pop in the same cycle leave occupancy unchanged.
  - Full: in_ready=0, so no push occurs.
  - Empty: mem_req=0.
  - Pointers wrap modulo FIFO_DEPTH.
- in_last with an empty program is not supported; each start requires at least one record.

Decomposition:
- Shared package PkgInstrEncoder:
  - field position/width constants, identical to the decoder's field layout;
  - group enum values 0..6;
  - state enum;
  - encode function returning the word plus the two error bits.
- The decoder package reuses the same field constants.
- Sub-module: sync_fifo (parameterised width/depth; push/pop/full/empty), instantiated with width 33 (word + last).

Test Plan:
- start, base_addr=0x1000; record g0 ra=1 rb=2 rc=3 op=4 last=1, immediate ack -> one write 0x01234000 @0x1000; done pulse; words_written=1; busy falls after DONE.
- g1 ra=5 rb=6 op=2 imm=0xBEEF, then g5 ra=1 rb=2 rc=3 op=1 imm=0xFFF8 last -> writes 0x1562BEEF @base, 0x51231FF8 @base+4; no errors.
- g5 imm=0x0800 -> word 0x51231800, err_imm_range=1 and stays set until next start; g9 -> word 0x00000000, err_bad_group=1.
- Hold mem_ack=0 for 10 cycles with 6 records offered -> in_ready drops after 4 accepted; mem_addr/mem_data stable; release ack -> all 6 written in order, consecutive addresses.
- base_addr=0xFFFFFFFC, two records -> second written @0x00000000.
- Assert rst_n low mid-RUN with 3 words queued -> all outputs at reset values next cycle; no further mem_req; start pulsed during RUN has no effect.
